stereo_frame_sched: RTL and testbench

- Sequences one stereo measurement cycle.
- Arms both camera-to-calc-RAM writers on a common frame boundary and holds write enables until both strips are captured.
- Freezes both calc RAMs, starts the disparity engine, then latches and holds the move result feeding the distance/BCD path.
- Sits between the two cam2ram writers, the calc engine and the display/BCD logic, all in the sysclk domain.

---
 rtl/stereo_frame_sched_if.sv | 27 ++
 rtl/stereo_frame_sched.sv | 180 ++++++++++++++++++
 tb/tb_stereo_frame_sched.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stereo_frame_sched_if.sv
// Handshake bundle between the stereo scheduler, both cam2ram writers, the calc engine and display logic.
// master = scheduler side; slave = the surrounding writers/engine/display.
interface stereo_frame_sched_if #(
   parameter int MOVE_W = 6
);
   logic [1:0]        vsync;
   logic [1:0]        cap_done;
   logic              calc_done;
   logic [MOVE_W-1:0] move_in;
   logic [1:0]        cap_en;
   logic              calc_start;
   logic              calc_busy;
   logic [MOVE_W-1:0] move_out;
   logic              move_valid;
   logic              err;
   logic [2:0]        state_dbg;

   modport master (
      input  vsync, cap_done, calc_done, move_in,
      output cap_en, calc_start, calc_busy, move_out, move_valid, err, state_dbg
   );

   modport slave (
      output vsync, cap_done, calc_done, move_in,
      input  cap_en, calc_start, calc_busy, move_out, move_valid, err, state_dbg
   );
endinterface

// File: rtl/stereo_frame_sched.sv
// Stereo measurement sequencer IDLE->ARM->CAPTURE->CALC->HOLD; MOVE_AVG_EN averages the last 4 moves.
// Latency: vsync pin to ARM 3 clk, 2nd cap_done to calc_start 1 clk, calc_done to move_out 1 clk; pulse inputs, no backpressure.
module stereo_frame_sched #(
   parameter int          MOVE_W      = 6,
   parameter logic [23:0] TIMEOUT     = 24'd2000000,
   parameter int          HOLD_FRAMES = 4
) (
   input logic                  sysclk,
   input logic                  rst_n,
   stereo_frame_sched_if.master bus
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      CAPTURE = 3'd2,
      CALC    = 3'd3,
      HOLD    = 3'd4
   } state_t;

   localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   state_t        state, state_nxt;
   logic [1:0]    vs_s1, vs_s2, vs_s3;
   logic [1:0]    vs_fall;
   logic          vs_left_rise;
   logic [1:0]    seen, seen_nxt;
   logic [1:0]    done, done_nxt;
   logic [23:0]   tmo_cnt, tmo_cnt_nxt;
   logic [HW-1:0] hold_cnt, hold_cnt_nxt;
   logic          err_q, err_nxt;
   logic          mv_vld_q;
   logic          accept;
   logic          tmo_hit;
   logic [1:0]    cap_en_c;
   logic          calc_start_c;
   logic          calc_busy_c;

   assign vs_fall      = vs_s3 & ~vs_s2;
   assign vs_left_rise = vs_s2[1] & ~vs_s3[1];

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state    <= IDLE;
         vs_s1    <= '0;
         vs_s2    <= '0;
         vs_s3    <= '0;
         seen     <= '0;
         done     <= '0;
         tmo_cnt  <= '0;
         hold_cnt <= '0;
         err_q    <= 1'b0;
         mv_vld_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         vs_s1    <= bus.vsync;
         vs_s2    <= vs_s1;
         vs_s3    <= vs_s2;
         seen     <= seen_nxt;
         done     <= done_nxt;
         tmo_cnt  <= tmo_cnt_nxt;
         hold_cnt <= hold_cnt_nxt;
         err_q    <= err_nxt;
         if (accept) mv_vld_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt    = state;
      seen_nxt     = seen;
      done_nxt     = done;
      tmo_cnt_nxt  = tmo_cnt;
      hold_cnt_nxt = hold_cnt;
      err_nxt      = err_q;
      accept       = 1'b0;
      tmo_hit      = 1'b0;
      cap_en_c     = 2'b00;
      calc_start_c = 1'b0;
      calc_busy_c  = 1'b0;
      case (state)
         IDLE: state_nxt = ARM;
         ARM: begin
            seen_nxt = seen | vs_fall;
            if (seen == 2'b11) begin
               state_nxt   = CAPTURE;
               seen_nxt    = 2'b00;
               done_nxt    = 2'b00;
               tmo_cnt_nxt = '0;
            end
         end
         CAPTURE: begin
            cap_en_c    = ~done;
            done_nxt    = done | bus.cap_done;
            tmo_cnt_nxt = tmo_cnt + 24'd1;
            // completing the pair on the last allowed cycle beats the timeout
            if (done_nxt == 2'b11) begin
               state_nxt   = CALC;
               done_nxt    = 2'b00;
               tmo_cnt_nxt = '0;
            end else if (tmo_cnt == TIMEOUT - 24'd1) begin
               tmo_hit = 1'b1;
            end
         end
         CALC: begin
            calc_busy_c  = 1'b1;
            calc_start_c = (tmo_cnt == '0);
            tmo_cnt_nxt  = tmo_cnt + 24'd1;
            if (bus.calc_done) begin
               accept       = 1'b1;
               state_nxt    = HOLD;
               hold_cnt_nxt = '0;
            end else if (tmo_cnt == TIMEOUT - 24'd1) begin
               tmo_hit = 1'b1;
            end
         end
         HOLD: begin
            if (HOLD_FRAMES == 0) begin
               state_nxt = ARM;
            end else if (vs_left_rise) begin
               if (hold_cnt == HW'(HOLD_FRAMES - 1)) begin
                  state_nxt    = ARM;
                  hold_cnt_nxt = '0;
               end else begin
                  hold_cnt_nxt = hold_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (tmo_hit) begin
         err_nxt     = 1'b1;
         state_nxt   = ARM;
         done_nxt    = 2'b00;
         tmo_cnt_nxt = '0;
         cap_en_c    = 2'b00;
         calc_busy_c = 1'b0;
      end
   end

   assign bus.cap_en     = cap_en_c;
   assign bus.calc_start = calc_start_c;
   assign bus.calc_busy  = calc_busy_c;
   assign bus.move_valid = mv_vld_q;
   assign bus.err        = err_q;
   assign bus.state_dbg  = state;

`ifdef MOVE_AVG_EN
   logic [MOVE_W-1:0] hist [4];
   logic [MOVE_W+1:0] sum;

   // first result after reset fills every slot so the average starts at that value
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) hist[i] <= '0;
         sum <= '0;
      end else if (accept) begin
         if (!mv_vld_q) begin
            for (int i = 0; i < 4; i++) hist[i] <= bus.move_in;
            sum <= {bus.move_in, 2'b00};
         end else begin
            hist[0] <= bus.move_in;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            hist[3] <= hist[2];
            sum     <= sum - {2'b00, hist[3]} + {2'b00, bus.move_in};
         end
      end
   end

   assign bus.move_out = sum[MOVE_W+1:2];
`else
   logic [MOVE_W-1:0] move_q;

   always_ff @(posedge sysclk) begin
      if (!rst_n)      move_q <= '0;
      else if (accept) move_q <= bus.move_in;
   end

   assign bus.move_out = move_q;
`endif
endmodule

// File: tb/tb_stereo_frame_sched.sv
// Randomized bench for stereo_frame_sched against a queue-based reference of accepted moves.
module tb_stereo_frame_sched;
   localparam int MOVE_W = 6;

   logic sysclk = 1'b0;
   logic rst_n  = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [MOVE_W-1:0] hist_q[$];
   logic [MOVE_W-1:0] exp_move  = '0;
   logic              exp_valid = 1'b0;
   logic              exp_err   = 1'b0;

   stereo_frame_sched_if #(.MOVE_W(MOVE_W)) bus ();

   stereo_frame_sched #(
      .MOVE_W(MOVE_W),
      .TIMEOUT(24'd100),
      .HOLD_FRAMES(4)
   ) dut (
      .sysclk(sysclk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 sysclk = ~sysclk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit exceeded, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   function automatic void model_reset();
      hist_q.delete();
      exp_move  = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
   endfunction

   function automatic void model_accept(input logic [MOVE_W-1:0] v);
      int s;
      if (!exp_valid) begin
         hist_q.delete();
         repeat (4) hist_q.push_back(v);
      end else begin
         hist_q.push_back(v);
         void'(hist_q.pop_front());
      end
      s = 0;
      foreach (hist_q[i]) s += int'(hist_q[i]);
`ifdef MOVE_AVG_EN
      exp_move = MOVE_W'(s / 4);
`else
      exp_move = v;
`endif
      exp_valid = 1'b1;
   endfunction

   task automatic frame_start(input int first, input int skew);
      bus.vsync = 2'b11;
      repeat (4) tick();
      bus.vsync[first] = 1'b0;
      repeat (skew) tick();
      bus.vsync = 2'b00;
      repeat (3) tick();
      checks++;
      if (bus.state_dbg !== 3'd1) begin errors++; $display("FAIL arm_wait: state_dbg=%0d expected 1", bus.state_dbg); end
      tick();
      checks++;
      if (bus.state_dbg !== 3'd2) begin errors++; $display("FAIL capture_entry: state_dbg=%0d expected 2", bus.state_dbg); end
      checks++;
      if (bus.cap_en !== 2'b11) begin errors++; $display("FAIL cap_en_open: cap_en=%b expected 11", bus.cap_en); end
   endtask

   task automatic do_capture(input int first, input int d1, input int gap);
      logic [1:0] fb;
      fb = (first == 0) ? 2'b01 : 2'b10;
      repeat (d1) begin
         tick();
         checks++;
         if (bus.cap_en !== 2'b11) begin errors++; $display("FAIL cap_en_wait: cap_en=%b expected 11", bus.cap_en); end
      end
      if (gap == 0) begin
         bus.cap_done = 2'b11;
         tick();
         bus.cap_done = 2'b00;
      end else begin
         bus.cap_done = fb;
         tick();
         bus.cap_done = 2'b00;
         checks++;
         if (bus.cap_en !== ~fb) begin errors++; $display("FAIL cap_en_drop: cap_en=%b expected %b", bus.cap_en, ~fb); end
         repeat (gap - 1) begin
            tick();
            checks++;
            if (bus.cap_en !== ~fb || bus.calc_busy !== 1'b0) begin
               errors++; $display("FAIL cap_en_partial: cap_en=%b busy=%b expected %b 0", bus.cap_en, bus.calc_busy, ~fb);
            end
         end
         bus.cap_done = ~fb;
         tick();
         bus.cap_done = 2'b00;
      end
      checks++;
      if (bus.state_dbg !== 3'd3) begin errors++; $display("FAIL calc_entry: state_dbg=%0d expected 3", bus.state_dbg); end
      checks++;
      if (bus.calc_start !== 1'b1 || bus.calc_busy !== 1'b1) begin
         errors++; $display("FAIL calc_start_pulse: start=%b busy=%b expected 1 1", bus.calc_start, bus.calc_busy);
      end
      checks++;
      if (bus.cap_en !== 2'b00) begin errors++; $display("FAIL cap_en_calc: cap_en=%b expected 00", bus.cap_en); end
   endtask

   task automatic do_calc(input int delay, input logic [MOVE_W-1:0] val);
      logic [MOVE_W-1:0] prev;
      prev = exp_move;
      if (delay > 0) begin
         tick();
         checks++;
         if (bus.calc_start !== 1'b0 || bus.calc_busy !== 1'b1) begin
            errors++; $display("FAIL calc_start_single: start=%b busy=%b expected 0 1", bus.calc_start, bus.calc_busy);
         end
         repeat (delay - 1) tick();
      end
      bus.move_in   = val;
      bus.calc_done = 1'b1;
      checks++;
      if (bus.move_out !== prev) begin errors++; $display("FAIL move_before_latch: move_out=%0d expected %0d", bus.move_out, prev); end
      tick();
      bus.calc_done = 1'b0;
      bus.move_in   = MOVE_W'($urandom);
      model_accept(val);
      checks++;
      if (bus.move_out !== exp_move) begin errors++; $display("FAIL move_latch: move_out=%0d expected %0d", bus.move_out, exp_move); end
      checks++;
      if (bus.move_valid !== 1'b1) begin errors++; $display("FAIL move_valid: got %b expected 1", bus.move_valid); end
      checks++;
      if (bus.state_dbg !== 3'd4 || bus.calc_busy !== 1'b0) begin
         errors++; $display("FAIL hold_entry: state_dbg=%0d busy=%b expected 4 0", bus.state_dbg, bus.calc_busy);
      end
      checks++;
      if (bus.err !== exp_err) begin errors++; $display("FAIL err_after_calc: err=%b expected %b", bus.err, exp_err); end
   endtask

   task automatic do_hold();
      for (int f = 0; f < 4; f++) begin
         bus.vsync = 2'b00;
         if (f == 0) begin
            bus.cap_done  = 2'b11;
            bus.calc_done = 1'b1;
            bus.move_in   = ~exp_move;
         end
         tick();
         bus.cap_done  = 2'b00;
         bus.calc_done = 1'b0;
         repeat (3) tick();
         bus.vsync = 2'b11;
         repeat (4) tick();
         checks++;
         if (bus.move_out !== exp_move) begin errors++; $display("FAIL move_hold: move_out=%0d expected %0d", bus.move_out, exp_move); end
         checks++;
         if (bus.state_dbg !== ((f == 3) ? 3'd1 : 3'd4)) begin
            errors++; $display("FAIL hold_count: frame %0d state_dbg=%0d expected %0d", f, bus.state_dbg, (f == 3) ? 1 : 4);
         end
      end
   endtask

   task automatic do_cycle(input int first, input int skew, input int d1, input int gap,
                           input int cdel, input logic [MOVE_W-1:0] val);
      frame_start(first, skew);
      do_capture(first, d1, gap);
      do_calc(cdel, val);
      do_hold();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if (bus.state_dbg !== 3'd0 || bus.cap_en !== 2'b00) begin
         errors++; $display("FAIL reset_state: state_dbg=%0d cap_en=%b expected 0 00", bus.state_dbg, bus.cap_en);
      end
      checks++;
      if (bus.calc_start !== 1'b0 || bus.calc_busy !== 1'b0 || bus.err !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl: start=%b busy=%b err=%b expected 0 0 0", bus.calc_start, bus.calc_busy, bus.err);
      end
      checks++;
      if (bus.move_out !== '0 || bus.move_valid !== 1'b0) begin
         errors++; $display("FAIL reset_move: move_out=%0d valid=%b expected 0 0", bus.move_out, bus.move_valid);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.state_dbg !== 3'd1) begin errors++; $display("FAIL idle_to_arm: state_dbg=%0d expected 1", bus.state_dbg); end
   endtask

   task automatic test_skew_and_stagger();
      frame_start(0, 10);
      do_capture(0, 0, 50);
      do_calc(3, 6'd23);
      do_hold();
   endtask

   task automatic test_timeout_boundary_win();
      frame_start(1, 2);
      bus.cap_done = 2'b01;
      tick();
      bus.cap_done = 2'b00;
      repeat (98) tick();
      bus.cap_done = 2'b10;
      tick();
      bus.cap_done = 2'b00;
      checks++;
      if (bus.state_dbg !== 3'd3 || bus.err !== 1'b0) begin
         errors++; $display("FAIL complete_beats_timeout: state_dbg=%0d err=%b expected 3 0", bus.state_dbg, bus.err);
      end
      do_calc(0, MOVE_W'($urandom));
      do_hold();
   endtask

   task automatic test_timeout();
      frame_start(0, 5);
      bus.cap_done = 2'b01;
      tick();
      bus.cap_done = 2'b00;
      repeat (98) tick();
      checks++;
      if (bus.state_dbg !== 3'd2 || bus.err !== 1'b0 || bus.cap_en !== 2'b00) begin
         errors++; $display("FAIL timeout_cycle: state_dbg=%0d err=%b cap_en=%b expected 2 0 00", bus.state_dbg, bus.err, bus.cap_en);
      end
      tick();
      exp_err = 1'b1;
      checks++;
      if (bus.state_dbg !== 3'd1 || bus.err !== 1'b1 || bus.cap_en !== 2'b00) begin
         errors++; $display("FAIL timeout_abort: state_dbg=%0d err=%b cap_en=%b expected 1 1 00", bus.state_dbg, bus.err, bus.cap_en);
      end
      checks++;
      if (bus.move_out !== exp_move || bus.move_valid !== exp_valid) begin
         errors++; $display("FAIL timeout_move: move_out=%0d valid=%b expected %0d %b", bus.move_out, bus.move_valid, exp_move, exp_valid);
      end
      do_cycle(1, 4, 7, 9, 5, MOVE_W'($urandom));
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 5; n++) begin
         do_cycle(int'($urandom_range(0, 1)), int'($urandom_range(0, 12)), int'($urandom_range(0, 20)),
                  int'($urandom_range(0, 40)), int'($urandom_range(0, 20)), MOVE_W'($urandom));
      end
   endtask

   task automatic test_reset_mid_capture();
      frame_start(0, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      model_reset();
      checks++;
      if (bus.state_dbg !== 3'd0 || bus.cap_en !== 2'b00) begin
         errors++; $display("FAIL reset_abort: state_dbg=%0d cap_en=%b expected 0 00", bus.state_dbg, bus.cap_en);
      end
      checks++;
      if (bus.move_valid !== 1'b0 || bus.err !== 1'b0 || bus.move_out !== '0) begin
         errors++; $display("FAIL reset_abort_flags: valid=%b err=%b move_out=%0d expected 0 0 0", bus.move_valid, bus.err, bus.move_out);
      end
   endtask

   task automatic test_move_sequence();
      logic [MOVE_W-1:0] vals [4];
      logic [MOVE_W-1:0] want [4];
      vals = '{6'd8, 6'd8, 6'd8, 6'd20};
`ifdef MOVE_AVG_EN
      want = '{6'd8, 6'd8, 6'd8, 6'd11};
`else
      want = '{6'd8, 6'd8, 6'd8, 6'd20};
`endif
      for (int k = 0; k < 4; k++) begin
         frame_start(k % 2, k);
         do_capture(k % 2, 2, k);
         do_calc(k, vals[k]);
         checks++;
         if (bus.move_out !== want[k]) begin
            errors++; $display("FAIL move_sequence: step %0d move_out=%0d expected %0d", k, bus.move_out, want[k]);
         end
         do_hold();
      end
   endtask

   initial begin
      bus.vsync     = 2'b11;
      bus.cap_done  = 2'b00;
      bus.calc_done = 1'b0;
      bus.move_in   = '0;
      model_reset();
      test_reset();
      test_skew_and_stagger();
      test_timeout_boundary_win();
      test_timeout();
      test_back_to_back();
      test_reset_mid_capture();
      test_move_sequence();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
